axi_lite_regfile: RTL and testbench
===================================

Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the team's single-FSM AXI-lite slave.
- Independent read and write paths. AW and W are accepted in any order, and byte-lane strobes are honoured.
- Out-of-range accesses return DECERR; a configurable read-only register window returns SLVERR on write.
- Sits behind the interconnect as the generic control/status register bank for peripheral blocks.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- NUM_REGS, 32, number of data-width registers; any value 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_BASE, NUM_REGS, first read-only register index; registers RO_BASE..NUM_REGS-1 are read-only. Default: none read-only.
- RESET_VAL, 0, reset value of every register.

Ports:
- ACLK  input  1  clock; all logic is on the rising edge.
- ARESET  input  1  asynchronous, active-high reset.
- AWADDR  input  ADDR_WIDTH  write address.
- AWVALID  input  1  write address valid.
- AWREADY  output  1  write address ready.
- WDATA  input  DATA_WIDTH  write data.
- WSTRB  input  DATA_WIDTH/8  byte-lane write strobes.
- WVALID  input  1  write data valid.
- WREADY  output  1  write data ready.
- BRESP  output  2  write response.
- BVALID  output  1  write response valid.
- BREADY  input  1  write response ready.
- ARADDR  input  ADDR_WIDTH  read address.
- ARVALID  input  1  read address valid.
- ARREADY  output  1  read address ready.
- RDATA  output  DATA_WIDTH  read data.
- RRESP  output  2  read response.
- RVALID  output  1  read data valid.
- RREADY  input  1  read data ready.

Behaviour:
- Reset (asynchronous, immediate on ARESET=1):
  - All outputs are 0; all registers are RESET_VAL; held flags are cleared.
  - Reset mid-transaction abandons that transaction; no response is issued after reset.
  - The first cycle after ARESET falls: AWREADY=WREADY=ARREADY=1.
- Address decode:
  - Register index = ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - index >= NUM_REGS → DECERR (2'b11).
- Write path, states W_COLLECT and W_RESP:
  - W_COLLECT: flags aw_held and w_held capture AWADDR and WDATA/WSTRB on their respective handshakes. AWREADY = !aw_held; WREADY = !w_held.
  - Commit occurs at the edge where the second of AW/W handshakes; same-cycle AW and W counts as simultaneous second. Commit uses held values or live bus values as applicable.
  - At commit, byte k of register[index] is updated iff WSTRB[k]=1.
  - At commit, BRESP = OKAY if the register is writable, SLVERR (2'b10) if index is in the read-only window (no update), DECERR if out of range (no update).
  - At commit, held flags clear and the FSM moves to W_RESP.
  - W_RESP: BVALID=1, AWREADY=WREADY=0. BVALID and BRESP stay stable until BREADY; on BVALID&BREADY the FSM returns to W_COLLECT.
  - Minimum write latency: BVALID is high the cycle after the second handshake.
  - WSTRB=0 on a writable register gives OKAY with no change.
- Read path, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID, RDATA and RRESP are registered and the FSM moves to R_DATA.
  - RDATA = register contents, or 0 on DECERR.
  - R_DATA: RVALID=1, ARREADY=0. RDATA and RRESP stay stable until RREADY; on RVALID&RREADY the FSM returns to R_IDLE.
  - Read latency: RVALID is high the cycle after the AR handshake.
  - Read-only registers read with OKAY.
- Concurrency:
  - The read and write FSMs run fully in parallel.
  - If a read AR handshake and a write commit to the same index fall on the same edge, the read returns the pre-write value.
- Back-to-back: the next AW/W/AR is accepted the cycle after the B/R handshake; there is no combinational path from BREADY/RREADY to AWREADY/ARREADY.
- No outstanding-transaction queueing beyond one per direction.

Test Plan:
- AW+W same cycle: addr 0x08, data 0xDEADBEEF, strb 0xF → reg2=0xDEADBEEF, BVALID next cycle with BRESP=00. Subsequent read of 0x08 returns 0xDEADBEEF with RRESP=00 and RVALID one cycle after AR.
- W three cycles before AW: data 0x11223344, strb 0x5, then addr 0x0C, reg3 initially 0 → reg3=0x00220044. WREADY stays low while w_held; BRESP=00.
- Out of range (NUM_REGS=32): write 0x80 and read 0x80 → BRESP=11 with no register change; RDATA=0 with RRESP=11.
- RO_BASE=30: write 0x78 (index 30) with 0xFFFFFFFF → BRESP=10; a read still returns RESET_VAL with RRESP=00.
- Backpressure: hold BREADY=0 and RREADY=0 for 5 cycles → BVALID, RVALID, BRESP, RDATA stable throughout; AWREADY=WREADY=ARREADY=0 until the respective handshake completes.
- Assert ARESET while in W_RESP and R_DATA → BVALID=RVALID=0 immediately, registers=RESET_VAL. After release: READYs are 1 and no stale response appears.

Source files
------------

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle for the register file: five channels, master and slave views.
interface axi_lite_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file. Independent read and write FSMs, byte strobes,
// DECERR for out-of-range indices, SLVERR on writes into the read-only top window.
module axi_lite_regfile #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 32,
  parameter int unsigned           RO_BASE    = NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_lite_regfile_if.slave bus
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned OffsW   = $clog2(StrbW);
  localparam int unsigned IdxW    = ADDR_WIDTH - OffsW;
  localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Index comparisons are done one bit wider than the address so NUM_REGS = 2^IdxW fits.
  localparam logic [ADDR_WIDTH:0] NumRegsW = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] RoBaseW  = (ADDR_WIDTH + 1)'(RO_BASE);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic {WCollect, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  w_state_e              w_state_q;
  logic                  aw_held_q, w_held_q;
  logic [IdxW-1:0]       aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [StrbW-1:0]      w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  r_state_e              r_state_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  awready, wready, aw_hs, w_hs, commit;
  logic [IdxW-1:0]       c_idx_raw;
  logic [ADDR_WIDTH:0]   c_idx;
  logic [RegIdxW-1:0]    c_sel;
  logic [DATA_WIDTH-1:0] c_data;
  logic [StrbW-1:0]      c_strb;
  logic                  c_wr;
  logic [1:0]            c_resp;

  logic [IdxW-1:0]       r_idx_raw;
  logic [ADDR_WIDTH:0]   r_idx;
  logic                  r_oor;

  // Readies come only from state flops (masked during reset), never from BREADY/RREADY.
  assign awready     = !ARESET && (w_state_q == WCollect) && !aw_held_q;
  assign wready      = !ARESET && (w_state_q == WCollect) && !w_held_q;
  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.ARREADY = !ARESET && (r_state_q == RIdle);
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  assign aw_hs  = bus.AWVALID && awready;
  assign w_hs   = bus.WVALID && wready;
  // Commit on the edge where the later of AW/W lands (or both together).
  assign commit = (w_state_q == WCollect) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // Commit decode: prefer held values, otherwise take the live bus.
  always_comb begin
    c_idx_raw = aw_held_q ? aw_idx_q : bus.AWADDR[ADDR_WIDTH-1:OffsW];
    c_data    = w_held_q ? w_data_q : bus.WDATA;
    c_strb    = w_held_q ? w_strb_q : bus.WSTRB;
    c_idx     = {1'b0, {OffsW{1'b0}}, c_idx_raw};
    c_sel     = c_idx_raw[RegIdxW-1:0];
    c_wr      = 1'b0;
    if (c_idx >= NumRegsW) begin
      c_resp = RespDecerr;
    end else if (c_idx >= RoBaseW) begin
      c_resp = RespSlverr;
    end else begin
      c_resp = RespOkay;
      c_wr   = 1'b1;
    end
  end

  // Read decode.
  always_comb begin
    r_idx_raw = bus.ARADDR[ADDR_WIDTH-1:OffsW];
    r_idx     = {1'b0, {OffsW{1'b0}}, r_idx_raw};
    r_oor     = (r_idx >= NumRegsW);
  end

  // Write FSM: collect AW/W in either order, commit with strobes, hold B until BREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= WCollect;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      unique case (w_state_q)
        WCollect: begin
          if (commit) begin
            for (int k = 0; k < StrbW; k++) begin
              if (c_wr && c_strb[k]) regs_q[c_sel][8*k +: 8] <= c_data[8*k +: 8];
            end
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bresp_q   <= c_resp;
            bvalid_q  <= 1'b1;
            w_state_q <= WResp;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              aw_idx_q  <= bus.AWADDR[ADDR_WIDTH-1:OffsW];
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              w_data_q <= bus.WDATA;
              w_strb_q <= bus.WSTRB;
            end
          end
        end
        WResp: begin
          if (bus.BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= WCollect;
          end
        end
      endcase
    end
  end

  // Read FSM: register data/response on AR, hold until RREADY. A same-edge commit is
  // not yet visible here, so the read returns the pre-write value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= RIdle;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (bus.ARVALID) begin
            rdata_q   <= r_oor ? '0 : regs_q[r_idx_raw[RegIdxW-1:0]];
            rresp_q   <= r_oor ? RespDecerr : RespOkay;
            rvalid_q  <= 1'b1;
            r_state_q <= RData;
          end
        end
        RData: begin
          if (bus.RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= RIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (NUM_REGS=32, RO_BASE=30, RESET_VAL=0).
module tb_axi_lite_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  axi_lite_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_regfile #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (32),
    .RO_BASE   (30),
    .RESET_VAL (32'h0)
  ) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive AW+W together; return what the B channel shows one cycle later.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic bv, output logic [1:0] br);
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    @(negedge clk);
    bv = bus.BVALID; br = bus.BRESP;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  // Issue AR; return what the R channel shows one cycle later.
  task automatic do_read(input logic [31:0] addr, output logic rv,
                         output logic [31:0] rd, output logic [1:0] rr);
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    @(negedge clk);
    rv = bus.RVALID; rd = bus.RDATA; rr = bus.RRESP;
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
    end
    n_tests++;
    if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {bus.BRESP, bus.RRESP, bus.RDATA});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 111",
               {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
  endtask

  task automatic test_aw_w_same();
    logic bv, rv; logic [1:0] br, rr; logic [31:0] rd;
    do_write(32'h08, 32'hDEADBEEF, 4'hF, bv, br);
    n_tests++;
    if ({bv, br} !== 3'b100) begin
      n_fail++;
      $display("FAIL same_cycle_b: got bvalid=%b bresp=%b required 1/00", bv, br);
    end
    n_tests++;
    if (bus.AWREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_awready: got %b required 1", bus.AWREADY);
    end
    do_read(32'h08, rv, rd, rr);
    n_tests++;
    if ({rv, rd, rr} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
      n_fail++;
      $display("FAIL same_cycle_read: got %b %h %b required 1 deadbeef 00", rv, rd, rr);
    end
  endtask

  task automatic test_w_first();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'h5; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.WREADY, bus.AWREADY, bus.BVALID} !== 3'b010) begin
        n_fail++;
        $display("FAIL w_held_ready: cyc %0d got %b required 010", i,
                 {bus.WREADY, bus.AWREADY, bus.BVALID});
      end
      if (i < 2) @(negedge clk);
    end
    bus.AWADDR = 32'h0C; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    n_tests++;
    if ({bus.BVALID, bus.BRESP} !== 3'b100) begin
      n_fail++;
      $display("FAIL w_first_b: got %b required 100", {bus.BVALID, bus.BRESP});
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    do_read(32'h0C, rv, rd, rr);
    n_tests++;
    if ({rd, rr} !== {32'h00220044, 2'b00}) begin
      n_fail++;
      $display("FAIL w_first_data: got %h/%b required 00220044/00", rd, rr);
    end
  endtask

  task automatic test_aw_first();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    n_tests++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b010) begin
      n_fail++;
      $display("FAIL aw_held_ready: got %b required 010", {bus.AWREADY, bus.WREADY, bus.BVALID});
    end
    bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'hC; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    n_tests++;
    if ({bus.BVALID, bus.BRESP} !== 3'b100) begin
      n_fail++;
      $display("FAIL aw_first_b: got %b required 100", {bus.BVALID, bus.BRESP});
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    do_read(32'h10, rv, rd, rr);
    n_tests++;
    if (rd !== 32'hA5A50000) begin
      n_fail++;
      $display("FAIL aw_first_data: got %h required a5a50000", rd);
    end
  endtask

  task automatic test_strb_zero();
    logic bv, rv; logic [1:0] br, rr; logic [31:0] rd;
    do_write(32'h08, 32'h12345678, 4'h0, bv, br);
    do_read(32'h08, rv, rd, rr);
    n_tests++;
    if ({br, rd} !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL strb_zero: got %b/%h required 00/deadbeef", br, rd);
    end
  endtask

  task automatic test_out_of_range();
    logic bv, rv; logic [1:0] br, rr; logic [31:0] rd;
    do_write(32'h80, 32'hFFFFFFFF, 4'hF, bv, br);
    n_tests++;
    if ({bv, br} !== 3'b111) begin
      n_fail++;
      $display("FAIL oor_bresp: got %b/%b required 1/11", bv, br);
    end
    do_read(32'h80, rv, rd, rr);
    n_tests++;
    if ({rv, rd, rr} !== {1'b1, 32'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL oor_read: got %b %h %b required 1 0 11", rv, rd, rr);
    end
    do_read(32'h00, rv, rd, rr);
    n_tests++;
    if ({rd, rr} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL oor_alias_reg0: got %h/%b required 0/00", rd, rr);
    end
  endtask

  task automatic test_read_only();
    logic bv, rv; logic [1:0] br, rr; logic [31:0] rd;
    do_write(32'h78, 32'hFFFFFFFF, 4'hF, bv, br);
    n_tests++;
    if (br !== 2'b10) begin
      n_fail++;
      $display("FAIL ro_bresp: got %b required 10", br);
    end
    do_read(32'h78, rv, rd, rr);
    n_tests++;
    if ({rd, rr} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL ro_read: got %h/%b required 0/00", rd, rr);
    end
    do_write(32'h74, 32'h5A5A0001, 4'hF, bv, br);
    do_read(32'h74, rv, rd, rr);
    n_tests++;
    if ({br, rd} !== {2'b00, 32'h5A5A0001}) begin
      n_fail++;
      $display("FAIL ro_boundary_rw: got %b/%h required 00/5a5a0001", br, rd);
    end
  endtask

  task automatic test_backpressure();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h08; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({bus.BVALID, bus.BRESP, bus.RVALID, bus.RRESP, bus.RDATA} !==
          {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF}) begin
        n_fail++;
        $display("FAIL bp_hold: cyc %0d got %b %b %b %b %h", i,
                 bus.BVALID, bus.BRESP, bus.RVALID, bus.RRESP, bus.RDATA);
      end
      n_tests++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
        n_fail++;
        $display("FAIL bp_ready: cyc %0d got %b required 000", i,
                 {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
      @(negedge clk);
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    n_tests++;
    if ({bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY} !== 5'b00111) begin
      n_fail++;
      $display("FAIL bp_release: got %b required 00111",
               {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
    do_read(32'h14, rv, rd, rr);
    n_tests++;
    if (rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL bp_data: got %h required 0badf00d", rd);
    end
  endtask

  task automatic test_same_edge();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h08; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    n_tests++;
    if ({bus.BVALID, bus.RVALID, bus.RDATA} !== {2'b11, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL same_edge_old: got %b %b %h required 1 1 deadbeef",
               bus.BVALID, bus.RVALID, bus.RDATA);
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    do_read(32'h08, rv, rd, rr);
    n_tests++;
    if (rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL same_edge_new: got %h required cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic rv; logic [1:0] rr; logic [31:0] rd;
    bus.AWADDR = 32'h04; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h08; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    n_tests++;
    if ({bus.BVALID, bus.RVALID} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_pre: got %b required 11", {bus.BVALID, bus.RVALID});
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.BVALID, bus.RVALID, bus.RDATA} !== 34'h0) begin
      n_fail++;
      $display("FAIL mid_async: got %b %b %h required 0 0 0", bus.BVALID, bus.RVALID, bus.RDATA);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b11100) begin
        n_fail++;
        $display("FAIL mid_release: cyc %0d got %b required 11100", i,
                 {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
      end
    end
    do_read(32'h08, rv, rd, rr);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reg2_reset: got %h required 0", rd);
    end
    do_read(32'h04, rv, rd, rr);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reg1_reset: got %h required 0", rd);
    end
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    test_reset();
    test_aw_w_same();
    test_w_first();
    test_aw_first();
    test_strb_zero();
    test_out_of_range();
    test_read_only();
    test_backpressure();
    test_same_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
